// File: rtl/vote_recorder.sv
// Voting-machine front end: synchronises and debounces four candidate buttons, accepts one
// vote per clean single-button press in vote mode, and keeps saturating per-candidate tallies.
module vote_recorder #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned LOCKOUT_CYCLES  = 100_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       mode,
    input  logic       candidate1_button,
    input  logic       candidate2_button,
    input  logic       candidate3_button,
    input  logic       candidate4_button,
    output logic [7:0] candidate1_vote,
    output logic [7:0] candidate2_vote,
    output logic [7:0] candidate3_vote,
    output logic [7:0] candidate4_vote,
    output logic [9:0] total_votes,
    output logic       valid_vote_casted,
    output logic       invalid_press,
    output logic       busy
);

    localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HoW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HoW-1:0] HoLoad = HoW'(LOCKOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StCast,
        StReject,
        StWaitRelease,
        StHoldoff
    } state_e;

    logic [3:0]     raw;
    logic [3:0]     sync1_q, sync2_q;
    logic [3:0]     deb_q, deb_prev_q;
    logic [3:0]     armed_q;
    logic [1:0]     fill_q;
    logic [DbW-1:0] db_cnt_q [4];
    logic [3:0]     press;
    logic           multi_press;
    logic           other_high;

    state_e         state_q, state_d;
    logic [HoW-1:0] hold_q, hold_d;
    logic [7:0]     tally_q [4];
    logic [9:0]     total_q;
    logic           valid_q, invalid_q, busy_q;
    logic           cast_now, reject_now;

    assign raw = {candidate4_button, candidate3_button, candidate2_button, candidate1_button};

    // A button is armed only once it has been seen released after reset, so a button held
    // through reset cannot register as a fresh press.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            armed_q    <= '0;
            fill_q     <= '0;
            for (int k = 0; k < 4; k++) begin
                db_cnt_q[k] <= '0;
            end
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            if (fill_q != 2'd2) begin
                fill_q <= fill_q + 2'd1;
            end
            armed_q <= armed_q | ({4{fill_q == 2'd2}} & ~sync2_q & ~deb_q);
            for (int k = 0; k < 4; k++) begin
                if (sync2_q[k] == deb_q[k]) begin
                    db_cnt_q[k] <= '0;
                end else if (db_cnt_q[k] == DbLast) begin
                    deb_q[k]    <= sync2_q[k];
                    db_cnt_q[k] <= '0;
                end else begin
                    db_cnt_q[k] <= db_cnt_q[k] + DbW'(1);
                end
            end
        end
    end

    assign press       = deb_q & ~deb_prev_q & armed_q;
    assign multi_press = (press & (press - 4'd1)) != 4'd0;
    assign other_high  = (deb_q & ~press) != 4'd0;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        unique case (state_q)
            StIdle: begin
                if (!mode && press != 4'd0) begin
                    state_d = (multi_press || other_high) ? StReject : StCast;
                end
            end
            StCast, StReject: state_d = StWaitRelease;
            StWaitRelease: begin
                if (deb_q == 4'd0) begin
                    state_d = StHoldoff;
                    hold_d  = HoLoad;
                end
            end
            StHoldoff: begin
                if (hold_q == '0) begin
                    state_d = StIdle;
                end else begin
                    hold_d = hold_q - HoW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign cast_now   = (state_q == StIdle) && (state_d == StCast);
    assign reject_now = (state_q == StIdle) && (state_d == StReject);

    // Tallies update on the edge entering CAST so the registered outputs show the new
    // count and the pulse during the CAST cycle itself.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            hold_q    <= '0;
            total_q   <= '0;
            valid_q   <= 1'b0;
            invalid_q <= 1'b0;
            busy_q    <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                tally_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            valid_q   <= cast_now;
            invalid_q <= reject_now;
            busy_q    <= (state_d != StIdle);
            if (cast_now) begin
                for (int k = 0; k < 4; k++) begin
                    if (press[k] && tally_q[k] != 8'hFF) begin
                        tally_q[k] <= tally_q[k] + 8'd1;
                    end
                end
                if (total_q != 10'h3FF) begin
                    total_q <= total_q + 10'd1;
                end
            end
        end
    end

    assign candidate1_vote   = tally_q[0];
    assign candidate2_vote   = tally_q[1];
    assign candidate3_vote   = tally_q[2];
    assign candidate4_vote   = tally_q[3];
    assign total_votes       = total_q;
    assign valid_vote_casted = valid_q;
    assign invalid_press     = invalid_q;
    assign busy              = busy_q;

endmodule
